// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT peak detector.
package fft_pkg;
   localparam int DATA_W = 16;
   localparam int N_BINS = 8;
   localparam int IDX_W  = $clog2(N_BINS);
   localparam int MAG_W  = DATA_W + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;
endpackage

// File: rtl/mag_approx.sv
// Approximate complex magnitude: max(|re|,|im|) + min(|re|,|im|)/2.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module mag_approx #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] re,
   input  logic [DATA_W-1:0] im,
   output logic [DATA_W:0]   mag
);
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [DATA_W-1:0] mx;
   logic [DATA_W-1:0] mn;

   always_comb begin
      // Unsigned abs: the most negative input maps to 2^(DATA_W-1) without saturating.
      a   = re[DATA_W-1] ? (~re + 1'b1) : re;
      b   = im[DATA_W-1] ? (~im + 1'b1) : im;
      mx  = (a > b) ? a : b;
      mn  = (a > b) ? b : a;
      mag = {1'b0, mx} + {2'b00, mn[DATA_W-1:1]};
   end
endmodule

// File: rtl/fft_peak_detect.sv
// Streaming per-frame spectral peak detector with sequence checking.
// Latency: peak_valid two edges after the edge that samples the last bin.
// Backpressure: none; accepts one bin per in_valid cycle, gaps allowed.
module fft_peak_detect #(
   parameter int          DATA_W  = fft_pkg::DATA_W,
   parameter int          N_BINS  = fft_pkg::N_BINS,
   parameter int          IDX_W   = fft_pkg::IDX_W,
   parameter int unsigned THRESH  = 0,
   parameter bit          SKIP_DC = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_re,
   input  logic [DATA_W-1:0] in_im,
   input  logic [IDX_W-1:0]  in_index,
   input  logic              in_valid,
   output logic [IDX_W-1:0]  peak_index,
   output logic [DATA_W:0]   peak_mag,
   output logic              peak_above,
   output logic              peak_valid,
   output logic              seq_err,
   output logic [15:0]       frame_cnt
);
   import fft_pkg::*;

   localparam int              MW       = DATA_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS - 1);
   localparam logic [MW-1:0]    THRESH_V = MW'(THRESH);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  exp_q, exp_d;
   logic              seq_err_q, seq_err_d;
   logic [DATA_W-1:0] re_q, re_d, im_q, im_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              acc_q, acc_d, start_q, start_d, close_q, close_d;
   logic [MW-1:0]     max_q, max_d;
   logic [IDX_W-1:0]  max_idx_q, max_idx_d;
   logic              max_vld_q, max_vld_d;
   logic              close_b_q, close_b_d;
   logic [IDX_W-1:0]  peak_index_q, peak_index_d;
   logic [MW-1:0]     peak_mag_q, peak_mag_d;
   logic              peak_above_q, peak_above_d;
   logic              peak_valid_q, peak_valid_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [MW-1:0]     mag;

   // Sequencing FSM; decisions travel down the pipe as acc/start/close flags.
   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      seq_err_d = 1'b0;
      acc_d     = 1'b0;
      start_d   = 1'b0;
      close_d   = 1'b0;
      re_d      = in_re;
      im_d      = in_im;
      idx_d     = in_index;
      case (state_q)
         IDLE: begin
            if (in_valid && in_index == '0) begin
               acc_d   = 1'b1;
               start_d = 1'b1;
               exp_d   = IDX_W'(1);
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               if (in_index == exp_q) begin
                  acc_d = 1'b1;
                  exp_d = exp_q + 1'b1;
                  if (in_index == LAST_IDX) begin
                     close_d = 1'b1;
                     state_d = IDLE;
                  end
               end else if (in_index == '0) begin
                  seq_err_d = 1'b1;
                  acc_d     = 1'b1;
                  start_d   = 1'b1;
                  exp_d     = IDX_W'(1);
               end else begin
                  seq_err_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   mag_approx #(.DATA_W(DATA_W)) u_mag (
      .re  (re_q),
      .im  (im_q),
      .mag (mag)
   );

   // Stage B running max; a frame start re-seeds it so a dropped frame leaves no residue.
   always_comb begin
      max_d     = max_q;
      max_idx_d = max_idx_q;
      max_vld_d = max_vld_q;
      close_b_d = acc_q & close_q;
      if (acc_q) begin
         if (start_q) begin
            if (SKIP_DC) begin
               max_d     = '0;
               max_idx_d = '0;
               max_vld_d = 1'b0;
            end else begin
               max_d     = mag;
               max_idx_d = idx_q;
               max_vld_d = 1'b1;
            end
         end else if (!max_vld_q || mag > max_q) begin
            max_d     = mag;
            max_idx_d = idx_q;
            max_vld_d = 1'b1;
         end
      end
   end

   // Output stage reads the closed frame's max on the same edge stage B may re-seed it.
   always_comb begin
      peak_index_d = peak_index_q;
      peak_mag_d   = peak_mag_q;
      peak_above_d = peak_above_q;
      frame_cnt_d  = frame_cnt_q;
      peak_valid_d = close_b_q;
      if (close_b_q) begin
         peak_index_d = max_idx_q;
         peak_mag_d   = max_q;
         peak_above_d = (max_q > THRESH_V);
         frame_cnt_d  = frame_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         exp_q        <= '0;
         seq_err_q    <= 1'b0;
         re_q         <= '0;
         im_q         <= '0;
         idx_q        <= '0;
         acc_q        <= 1'b0;
         start_q      <= 1'b0;
         close_q      <= 1'b0;
         max_q        <= '0;
         max_idx_q    <= '0;
         max_vld_q    <= 1'b0;
         close_b_q    <= 1'b0;
         peak_index_q <= '0;
         peak_mag_q   <= '0;
         peak_above_q <= 1'b0;
         peak_valid_q <= 1'b0;
         frame_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         exp_q        <= exp_d;
         seq_err_q    <= seq_err_d;
         re_q         <= re_d;
         im_q         <= im_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         start_q      <= start_d;
         close_q      <= close_d;
         max_q        <= max_d;
         max_idx_q    <= max_idx_d;
         max_vld_q    <= max_vld_d;
         close_b_q    <= close_b_d;
         peak_index_q <= peak_index_d;
         peak_mag_q   <= peak_mag_d;
         peak_above_q <= peak_above_d;
         peak_valid_q <= peak_valid_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign peak_index = peak_index_q;
   assign peak_mag   = peak_mag_q;
   assign peak_above = peak_above_q;
   assign peak_valid = peak_valid_q;
   assign seq_err    = seq_err_q;
   assign frame_cnt  = frame_cnt_q;
endmodule
